// File: rtl/console_pkg.sv
// Shared types and constants for the text console: CGA palette, clear FSM states,
// and helpers that split a cell attribute into its palette indices.
package console_pkg;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  typedef enum logic {IDLE, CLEAR} clear_state_e;

  function automatic logic [3:0] attr_fg(input logic [7:0] attr);
    return attr[3:0];
  endfunction

  function automatic logic [3:0] attr_bg(input logic [7:0] attr);
    return attr[7:4];
  endfunction

endpackage

// File: rtl/char_rom.sv
// Asynchronous 8x16 glyph ROM, address = {char[6:0], row}; MSB of data is the leftmost pixel.
// Only the glyphs the console currently needs are populated; all others render blank.
module char_rom (
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);

  always_comb begin
    data_o = 8'h00;
    case (addr_i[10:4])
      7'h41: begin
        case (addr_i[3:0])
          4'd2:                     data_o = 8'h10;
          4'd3:                     data_o = 8'h38;
          4'd4:                     data_o = 8'h6C;
          4'd5, 4'd6:               data_o = 8'hC6;
          4'd7:                     data_o = 8'hFE;
          4'd8, 4'd9, 4'd10, 4'd11: data_o = 8'hC6;
          default:                  data_o = 8'h00;
        endcase
      end
      7'h7F:   data_o = 8'hFF;
      default: data_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/console_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
module console_ram #(
  parameter int DEPTH = 2400,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/text_console.sv
// Text-mode renderer: character/attribute buffer, clear engine, blinking cursor and a
// two-stage pixel pipeline from x/y/video_on to RGB.
module text_console
  import console_pkg::*;
#(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 30,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [7:0] CLEAR_ATTR   = 8'h07
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    video_on,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [7:0]              wr_char,
  input  logic [7:0]              wr_attr,
  input  logic                    clear_req,
  input  logic                    cursor_en,
  input  logic [$clog2(COLS)-1:0] cursor_col,
  input  logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    wr_ready,
  output logic                    busy,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  clear_state_e      state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [15:0]       ram_wdata, ram_rdata;
  logic              host_wr_ok;

  assign busy       = (state_q == CLEAR);
  assign wr_ready   = ~busy;
  assign host_wr_ok = wr_en && wr_ready && (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);

  // The clear engine owns the write port while busy; host writes are simply dropped.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_we     = host_wr_ok;
    ram_waddr  = ADDR_W'(wr_row) * ADDR_W'(COLS) + ADDR_W'(wr_col);
    ram_wdata  = {wr_attr, wr_char};
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        ram_wdata = {CLEAR_ATTR, SPACE_CHAR};
        if (clr_addr_q == ADDR_W'(CELLS - 1)) state_d = IDLE;
        else clr_addr_d = clr_addr_q + ADDR_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  console_ram #(.DEPTH(CELLS), .WIDTH(16)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Stage 0: cell lookup plus the per-pixel qualifiers that travel alongside the read.
  logic       in_range, cursor_hit, at_origin;
  logic [2:0] xpix_q;
  logic [3:0] yrow_q;
  logic       von_q, in_range_q, cursor_hit_q, origin_q, blink_q;
  logic [FC_W-1:0] frame_cnt_q;

  assign ram_raddr  = ADDR_W'(y[9:4]) * ADDR_W'(COLS) + ADDR_W'(x[9:3]);
  assign in_range   = (int'(x) < COLS * 8) && (int'(y) < ROWS * 16);
  assign cursor_hit = (int'(x[9:3]) == int'(cursor_col)) && (int'(y[9:4]) == int'(cursor_row));
  assign at_origin  = (x == 10'd0) && (y == 10'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xpix_q       <= '0;
      yrow_q       <= '0;
      von_q        <= 1'b0;
      in_range_q   <= 1'b0;
      cursor_hit_q <= 1'b0;
      origin_q     <= 1'b0;
      frame_cnt_q  <= '0;
      blink_q      <= 1'b0;
    end else begin
      xpix_q       <= x[2:0];
      yrow_q       <= y[3:0];
      von_q        <= video_on;
      in_range_q   <= in_range;
      cursor_hit_q <= cursor_hit;
      origin_q     <= at_origin;
      if (at_origin && !origin_q) begin
        if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + FC_W'(1);
        end
      end
    end
  end

  // Stage 1: glyph lookup and colour select; a visible cursor inverts fg/bg.
  logic [7:0]  char_code, rom_data;
  logic [10:0] rom_addr;
  logic [23:0] fg, bg, rgb_d, rgb_q;
  logic        pix_bit, swap;

  assign char_code = ram_rdata[7:0];
  assign rom_addr  = 11'({char_code, yrow_q});

  char_rom u_rom (
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    pix_bit = rom_data[3'd7 - xpix_q];
    fg      = PALETTE[attr_fg(ram_rdata[15:8])];
    bg      = PALETTE[attr_bg(ram_rdata[15:8])];
    swap    = cursor_hit_q && cursor_en && blink_q;
    rgb_d   = '0;
    if (von_q && in_range_q) rgb_d = (pix_bit ^ swap) ? fg : bg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else rgb_q <= rgb_d;
  end

  assign VGA_R = rgb_q[23:16];
  assign VGA_G = rgb_q[15:8];
  assign VGA_B = rgb_q[7:0];

endmodule
